// File: rtl/dmem_ctrl_if.sv
// Core-side DMEM bus: byte address, write data, byte strobes and same-cycle read data.
interface dmem_ctrl_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wrdata;
  logic [3:0]  dmem_wrstb;
  logic [31:0] dmem_rddata;

  modport master (
    output dmem_addr,
    output dmem_wrdata,
    output dmem_wrstb,
    input  dmem_rddata
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wrdata,
    input  dmem_wrstb,
    output dmem_rddata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// DMEM responder: byte-strobed RAM plus MMIO window (cycle counter, TX FIFO, halt flag).
// Define DMEM_MMIO_TX_EN to build the TX FIFO and its valid/ready output stream.
module dmem_ctrl #(
  parameter int unsigned RAM_WORDS = 4096,
  parameter int unsigned TX_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave dmem,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       halt
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned TX_AW  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned LVL_W  = TX_AW + 1;

  localparam logic [5:0] OFF_CYC_LO  = 6'h00;
  localparam logic [5:0] OFF_CYC_HI  = 6'h01;
  localparam logic [5:0] OFF_TX_DATA = 6'h02;
  localparam logic [5:0] OFF_STATUS  = 6'h03;
  localparam logic [5:0] OFF_HALT    = 6'h04;

  logic              mmio_sel_c;
  logic              wr_c;
  logic [5:0]        reg_off_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic [31:0]       status_c;

  assign mmio_sel_c = dmem.dmem_addr[31];
  assign wr_c       = |dmem.dmem_wrstb;
  assign reg_off_c  = dmem.dmem_addr[7:2];
  assign ram_idx_c  = dmem.dmem_addr[RAM_AW+1:2];

  // RAM storage is deliberately outside reset so contents survive rst
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (!mmio_sel_c) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem.dmem_wrstb[i]) begin
          ram_q[ram_idx_c][8*i +: 8] <= dmem.dmem_wrdata[8*i +: 8];
        end
      end
    end
  end

  logic [63:0] cycle_q, cycle_d;
  logic        halt_q, halt_d;

  assign cycle_d = cycle_q + 64'd1;
  assign halt_d  = halt_q | (mmio_sel_c && (reg_off_c == OFF_HALT) && wr_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      halt_q  <= halt_d;
    end
  end

  assign halt = halt_q;

`ifdef DMEM_MMIO_TX_EN
  logic [7:0]       fifo_q [TX_DEPTH];
  logic [TX_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             empty_c, full_c, pop_c, push_req_c, push_c, ovf_clr_c;
  logic             unused_addr;

  assign empty_c    = (level_q == '0);
  assign full_c     = (level_q == LVL_W'(TX_DEPTH));
  assign pop_c      = !empty_c && tx_ready;
  assign push_req_c = mmio_sel_c && (reg_off_c == OFF_TX_DATA) && dmem.dmem_wrstb[0];
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_c     = push_req_c && (!full_c || pop_c);
  assign ovf_clr_c  = mmio_sel_c && (reg_off_c == OFF_STATUS) && dmem.dmem_wrstb[0]
                      && dmem.dmem_wrdata[2];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (push_c) wptr_d = wptr_q + TX_AW'(1);
    if (pop_c)  rptr_d = rptr_q + TX_AW'(1);
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (push_req_c && !push_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_c) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wptr_q] <= dmem.dmem_wrdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_valid    = !empty_c;
  assign tx_data     = empty_c ? 8'h00 : fifo_q[rptr_q];
  assign status_c    = {16'h0000, 8'(level_q), 5'b00000, ovf_q, full_c, empty_c};
  assign unused_addr = ^dmem.dmem_addr;
`else
  logic unused_tx;

  assign tx_valid  = 1'b0;
  assign tx_data   = 8'h00;
  assign status_c  = 32'h0000_0001;
  assign unused_tx = ^{dmem.dmem_addr, tx_ready};
`endif

  // Side-effect-free read mux
  always_comb begin
    dmem.dmem_rddata = 32'h0;
    if (!mmio_sel_c) begin
      dmem.dmem_rddata = ram_q[ram_idx_c];
    end else begin
      case (reg_off_c)
        OFF_CYC_LO: dmem.dmem_rddata = cycle_q[31:0];
        OFF_CYC_HI: dmem.dmem_rddata = cycle_q[63:32];
        OFF_STATUS: dmem.dmem_rddata = status_c;
        default:    dmem.dmem_rddata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_dmem_ctrl;
  localparam int unsigned RAM_WORDS = 4096;
  localparam int unsigned TX_DEPTH  = 16;
  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       halt;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.RAM_WORDS(RAM_WORDS), .TX_DEPTH(TX_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .dmem     (bus),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .halt     (halt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit [31:0]         m_ram [RAM_WORDS];
  bit [3:0]          m_vld [RAM_WORDS];
  longint unsigned   m_cycle;
  byte unsigned      m_q [$];
  bit                m_ovf;
  bit                m_halt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
`ifdef DMEM_MMIO_TX_EN
    int n;
    n = m_q.size();
    return {16'h0000, 8'(n), 5'b00000, m_ovf, (n == int'(TX_DEPTH)), (n == 0)};
`else
    return 32'h0000_0001;
`endif
  endfunction

  function automatic bit m_read(input logic [31:0] a, output logic [31:0] d);
    int unsigned idx;
    d = 32'h0;
    if (!a[31]) begin
      idx = (a >> 2) % RAM_WORDS;
      d = m_ram[idx];
      return (m_vld[idx] == 4'hF);
    end
    case (int'(a[7:2]))
      0:       d = m_cycle[31:0];
      1:       d = m_cycle[63:32];
      3:       d = m_status();
      default: d = 32'h0;
    endcase
    return 1'b1;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.dmem_addr   = a;
    bus.dmem_wrdata = d;
    bus.dmem_wrstb  = s;
  endtask

  // One clock cycle: compare outputs against the model, take the edge, advance the model
  task automatic tick();
    logic [31:0]  exp;
    logic [31:0]  a, d;
    logic [3:0]   s;
    bit           known, pop, full;
    int unsigned  idx;
    #1;
    known = m_read(bus.dmem_addr, exp);
    if (known) chk("rddata", bus.dmem_rddata, exp);
    chk("tx_valid", tx_valid, m_q.size() != 0);
    chk("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 0);
    chk("halt", halt, m_halt);
    a = bus.dmem_addr;
    d = bus.dmem_wrdata;
    s = bus.dmem_wrstb;
    @(posedge clk);
    if (!a[31]) begin
      idx = (a >> 2) % RAM_WORDS;
      for (int i = 0; i < 4; i++) begin
        if (s[i]) begin
          m_ram[idx][8*i +: 8] = d[8*i +: 8];
          m_vld[idx][i] = 1'b1;
        end
      end
    end
    if (rst) begin
      m_cycle = 0;
      m_q.delete();
      m_ovf  = 1'b0;
      m_halt = 1'b0;
    end else begin
      m_cycle++;
`ifdef DMEM_MMIO_TX_EN
      full = (m_q.size() == TX_DEPTH);
      pop  = tx_ready && (m_q.size() != 0);
      if (pop) void'(m_q.pop_front());
      if (a[31] && a[7:2] == 6'd2 && s[0]) begin
        if (!full || pop) m_q.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end
      if (a[31] && a[7:2] == 6'd3 && s[0] && d[2]) m_ovf = 1'b0;
`else
      full = 1'b0;
      pop  = 1'b0;
`endif
      if (a[31] && a[7:2] == 6'd4 && s != 4'h0) m_halt = 1'b1;
    end
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    drive(a, 32'h0, 4'h0);
    #1;
    chk(tag, bus.dmem_rddata, e);
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(a, d, s);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    rst      = 1'b1;
    tx_ready = 1'b0;
    drive(32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    m_cycle = 0;
    m_ovf   = 1'b0;
    m_halt  = 1'b0;

    // Reset state
    rd(32'h8000_000C, 32'h0000_0001, "rst_status");
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_halt", halt, 1'b0);
    rst = 1'b0;

    // Cycle counter after 100 edges
    drive(32'h8000_0000, 32'h0, 4'h0);
    repeat (100) tick();
    rd(32'h8000_0000, 32'd100, "cycle_lo");
    rd(32'h8000_0004, 32'd0, "cycle_hi");

    // Byte strobes and RAM aliasing
    wr(32'h0000_0040, 32'h1122_3344, 4'b1111);
    wr(32'h0000_0040, 32'h0000_00AA, 4'b0001);
    wr(32'h0000_0040, 32'h5500_0000, 4'b1000);
    rd(32'h0000_0040, 32'h5522_33AA, "strobe_merge");
    rd(32'h0000_4040, 32'h5522_33AA, "ram_alias");

    // Same-cycle read/write returns old data
    wr(32'h0000_0080, 32'h1, 4'b1111);
    drive(32'h0000_0080, 32'h2, 4'b1111);
    #1;
    chk("rw_old", bus.dmem_rddata, 32'h1);
    tick();
    rd(32'h0000_0080, 32'h2, "rw_new");

`ifdef DMEM_MMIO_TX_EN
    // Overflow with 17 pushes into a 16-deep FIFO
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) wr(32'h8000_0008, 32'(i), 4'b0001);
    rd(32'h8000_000C, 32'h0000_1006, "ovf_status");
    tx_ready = 1'b1;
    drive(32'h8000_0020, 32'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("drain_valid", tx_valid, 1'b1);
      chk("drain_data", tx_data, 8'(i));
      tick();
    end
    chk("drain_empty", tx_valid, 1'b0);
    rd(32'h8000_000C, 32'h0000_0005, "ovf_sticky");
    wr(32'h8000_000C, 32'h0000_0004, 4'b0001);
    rd(32'h8000_000C, 32'h0000_0001, "ovf_clear");

    // Push and pop together while full
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(32'h8000_0008, 32'h30 + 32'(i), 4'b0001);
    rd(32'h8000_000C, 32'h0000_1002, "full_status");
    tx_ready = 1'b1;
    wr(32'h8000_0008, 32'hA5, 4'b0001);
    tx_ready = 1'b0;
    rd(32'h8000_000C, 32'h0000_1002, "pushpop_status");
    tx_ready = 1'b1;
    drive(32'h8000_0020, 32'h0, 4'h0);
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk("pushpop_order", tx_data, (i == 16) ? 8'hA5 : 8'(32'h30 + i));
      tick();
    end
    chk("pushpop_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;
`endif

    // Halt request
    drive(32'h8000_0010, $urandom, 4'b0010);
    #1;
    chk("halt_pre", halt, 1'b0);
    tick();
    chk("halt_set", halt, 1'b1);
    drive(32'h8000_0020, 32'h0, 4'h0);
    repeat (3) tick();
    chk("halt_sticky", halt, 1'b1);

    // Reset mid-operation
`ifdef DMEM_MMIO_TX_EN
    for (int i = 0; i < 5; i++) wr(32'h8000_0008, 32'h60 + 32'(i), 4'b0001);
    chk("midrst_queued", tx_valid, 1'b1);
`endif
    rst      = 1'b1;
    tx_ready = 1'b1;
    drive(32'h8000_0020, 32'h0, 4'h0);
    tick();
    rst      = 1'b0;
    tx_ready = 1'b0;
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_halt", halt, 1'b0);
    rd(32'h8000_0000, 32'd0, "midrst_cycle");
    rd(32'h8000_000C, 32'h0000_0001, "midrst_status");
    rd(32'h0000_0040, 32'h5522_33AA, "midrst_ram");

`ifndef DMEM_MMIO_TX_EN
    wr(32'h8000_0008, 32'h77, 4'b0001);
    chk("notx_valid", tx_valid, 1'b0);
    rd(32'h8000_000C, 32'h0000_0001, "notx_status");
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      tx_ready = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        a = {1'b0, 31'($urandom)};
        a[RAM_AW+1:2] = RAM_AW'($urandom_range(16, 31));
      end else begin
        a = $urandom;
        a[31] = 1'b1;
        a[7:2] = 6'($urandom_range(0, 6));
      end
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if (rst) s = 4'h0;
      drive(a, $urandom, s);
      tick();
    end
    rst = 1'b0;
    drive(32'h8000_000C, 32'h0, 4'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the `mina` core's DMEM port. It terminates the core's zero-wait-state DMEM interface (address, write data, byte write strobes, same-cycle read data). Behind it sit a byte-strobed RAM and a small MMIO window: a 64-bit cycle counter, a byte TX FIFO with a valid/ready output stream, and a sticky simulation-halt flag. It is instantiated at SoC top level next to the IMEM, with `dmem_*` wired straight to the core.

## Interface
Parameters:
- `RAM_WORDS`, 4096: RAM depth in 32-bit words; power of two.
- `TX_DEPTH`, 16: TX FIFO depth in bytes; power of two, 2..128.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `dmem_addr`  in  32  byte address from the core, valid every cycle.
- `dmem_wrdata`  in  32  write data; lane i is bits [8i+7:8i].
- `dmem_wrstb`  in  4  byte write strobes; all zero means no write.
- `dmem_rddata`  out  32  combinational read data for `dmem_addr`.
- `tx_valid`  out  1  TX FIFO head is valid.
- `tx_data`  out  8  TX FIFO head byte; 8'h00 when empty.
- `tx_ready`  in  1  downstream accepts the byte; a pop occurs when `tx_valid && tx_ready`.
- `halt`  out  1  sticky halt request to the testbench.

## Operation
- Decode rules:
  - `dmem_addr[31]=0` selects RAM. The word index is `dmem_addr[log2(RAM_WORDS)+1:2]`; upper bits are ignored, so the RAM aliases.
  - `dmem_addr[31]=1` selects MMIO. The register is `dmem_addr[7:2]`; other bits are ignored.
  - `dmem_addr[1:0]` is ignored everywhere.
- Reads are side-effect free. The core drives the address on non-memory instructions, so reads must never change state.
- RAM:
  - Reads are asynchronous. On a clock edge, lane i is written when `dmem_wrstb[i]=1`.
  - RAM is not reset; contents survive `rst`.
- MMIO map (offset: access, meaning):
  - 0x00: RO. `CYCLE[31:0]`.
  - 0x04: RO. `CYCLE[63:32]`.
  - 0x08: WO. `TX_DATA`. A write with `dmem_wrstb[0]=1` pushes `dmem_wrdata[7:0]`. Reads return 0.
  - 0x0C: RW. `STATUS`:
    - Read: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] fill level, other bits 0.
    - Write with `dmem_wrstb[0]=1` and `dmem_wrdata[2]=1` clears overflow.
  - 0x10: WO. `HALT`. Any write (any strobe set) sets `halt`. Reads return 0.
  - All other offsets: reads return 0, writes are ignored.
- `CYCLE`: 64-bit counter, increments by 1 every non-reset cycle and wraps to 0 after all-ones. Software reads HI, LO, HI and retries if HI changed.
- TX FIFO:
  - Circular buffer with read/write pointers and a level counter of width log2(TX_DEPTH)+1.
  - A push is accepted when the FIFO is not full, or when a pop happens in the same cycle.
  - A push while full with no pop is dropped and sets overflow.
  - Push and pop in the same cycle: the level is unchanged and both pointers advance.
  - Push into an empty FIFO: no bypass. `tx_valid` rises the following cycle.
  - Data leaves in FIFO order, at most one byte per cycle.

## Timing
- Read latency is 0 cycles, combinational from `dmem_addr`. A read and write to the same location in one cycle returns the pre-edge (old) value; new data is visible the next cycle.
- All MMIO writes take effect at the edge ending the write cycle.
- Behaviour while `rst=1` at an edge, and the resulting reset values:
  - CYCLE = 0.
  - FIFO empty: pointers 0, level 0.
  - overflow = 0.
  - `halt` = 0.
  - `tx_valid` = 0, `tx_data` = 8'h00.
  - `dmem_rddata` follows decode with these reset values.
- Reset mid-operation discards queued TX bytes. A byte presented with `tx_valid && tx_ready` in the reset cycle is not considered transferred.
- CYCLE value: CYCLE reads N when N rising edges have occurred since the last edge with `rst=1`.
- `halt` rises the cycle after the HALT write and stays high until `rst`.

## Configuration
- `DMEM_MMIO_TX_EN` defined: the TX FIFO and TX stream are built as described.
- `DMEM_MMIO_TX_EN` undefined:
  - No FIFO storage is built.
  - `TX_DATA` writes are ignored.
  - `STATUS` reads 32'h0000_0001 (empty) and overflow-clear writes are ignored.
  - `tx_valid=0`, `tx_data=8'h00`, `tx_ready` is unused.
  - CYCLE, HALT and RAM are unchanged.

## Test plan
- Byte strobes: write 0x11223344 to 0x40 with strobes 4'b1111, then 0x000000AA with 4'b0001, then 0x5500_0000 with 4'b1000 -> reading 0x40 returns 0x552233AA; reading 0x4040 (alias with RAM_WORDS=4096) returns the same.
- Same-cycle read/write: hold addr 0x80, word 0x1, write 0x2 with 4'b1111 -> `dmem_rddata` = 0x1 that cycle, 0x2 the next.
- TX overflow: TX_DEPTH=16, `tx_ready=0`, push bytes 0x00..0x10 (17 pushes) -> STATUS = 0x0000_1006. Then `tx_ready=1` -> 0x00..0x0F emitted on 16 consecutive cycles, then `tx_valid=0` and STATUS = 0x0000_0005. Write STATUS 0x4 -> STATUS = 0x0000_0001.
- Simultaneous push/pop at full: FIFO full, `tx_ready=1` and push 0xA5 in the same cycle -> level stays 16, no overflow, 0xA5 emitted 16th after that edge.
- Counter/halt: release reset, read 0x8000_0000 after 100 edges -> 100, 0x8000_0004 -> 0. Write 0x8000_0010 -> `halt`=1 next cycle and stays high.
- Reset mid-operation: 5 bytes queued, `halt`=1, RAM[0x40]=0x552233AA, pulse `rst` one cycle -> `tx_valid`=0, STATUS=0x1, `halt`=0, CYCLE=0 after the edge, RAM[0x40] unchanged. With `DMEM_MMIO_TX_EN` undefined, a TX_DATA write leaves `tx_valid`=0 and STATUS=0x1.
